// File: rtl/ex_operand_stage_pkg.sv
// Shared ALU header: opcode encodings, flag bit positions and datapath defaults.
// Also holds the load-time carry conversion used by the ID/EX register.
package ex_operand_stage_pkg;

    localparam int DW_DEF = 16;
    localparam int RW_DEF = 3;

    localparam logic [3:0] A_AND    = 4'd0;
    localparam logic [3:0] A_OR     = 4'd1;
    localparam logic [3:0] A_XOR    = 4'd2;
    localparam logic [3:0] A_NOT    = 4'd3;
    localparam logic [3:0] A_ADD    = 4'd4;
    localparam logic [3:0] A_SUB    = 4'd5;
    localparam logic [3:0] A_SLL    = 4'd6;
    localparam logic [3:0] A_SRL    = 4'd7;
    localparam logic [3:0] A_SRA    = 4'd8;
    localparam logic [3:0] A_ADDPLS = 4'd9;
    localparam logic [3:0] A_SUBMNS = 4'd10;

    localparam int CF = 0;
    localparam int ZF = 1;
    localparam int NF = 2;

    // ADDC/SUBC with carry set become the +1 / -1 ALU variants; everything else passes.
    function automatic logic [3:0] carry_convert(input logic [3:0] op,
                                                 input logic       carry_use,
                                                 input logic       cf);
        logic [3:0] res;
        res = op;
        if (carry_use && cf) begin
            if (op == A_ADD)
                res = A_ADDPLS;
            else if (op == A_SUB)
                res = A_SUBMNS;
        end
        return res;
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Two-level priority forwarding mux: EX/MEM beats MEM/WB beats register-file data.
// Register 0 is forwarded like any other register.
module fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic [RW-1:0] rs_addr,
    input  logic [DW-1:0] rf_data,
    input  logic          exmem_reg_we,
    input  logic [RW-1:0] exmem_rd_addr,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_we,
    input  logic [RW-1:0] memwb_rd_addr,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] operand
);

    always_comb begin
        operand = rf_data;
        if (exmem_reg_we && (exmem_rd_addr == rs_addr))
            operand = exmem_result;
        else if (memwb_reg_we && (memwb_rd_addr == rs_addr))
            operand = memwb_result;
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with forwarding, immediate select, carry conversion
// and the architectural {NF,ZF,CF} flag register.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [3:0]    id_alu_op,
    input  logic [RW-1:0] id_rs1_addr,
    input  logic [RW-1:0] id_rs2_addr,
    input  logic [DW-1:0] id_rs1_data,
    input  logic [DW-1:0] id_rs2_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_use_imm,
    input  logic          id_carry_use,
    input  logic [RW-1:0] id_rd_addr,
    input  logic          id_reg_we,
    input  logic          id_flag_we,
    input  logic          exmem_reg_we,
    input  logic [RW-1:0] exmem_rd_addr,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_we,
    input  logic [RW-1:0] memwb_rd_addr,
    input  logic [DW-1:0] memwb_result,
    input  logic [2:0]    alu_flags,
    output logic          ex_valid,
    output logic [3:0]    ex_alu_op,
    output logic [DW-1:0] ex_operandA,
    output logic [DW-1:0] ex_operandB,
    output logic [RW-1:0] ex_rd_addr,
    output logic          ex_reg_we,
    output logic          ex_flag_we,
    output logic [2:0]    flags_q
);

    logic          vld_p1;
    logic [3:0]    alu_op_p1;
    logic [RW-1:0] rs1_addr_p1;
    logic [RW-1:0] rs2_addr_p1;
    logic [DW-1:0] rs1_data_p1;
    logic [DW-1:0] rs2_data_p1;
    logic [DW-1:0] imm_p1;
    logic          use_imm_p1;
    logic [RW-1:0] rd_addr_p1;
    logic          reg_we_p1;
    logic          flag_we_p1;

    logic          flag_upd;
    logic          cf_eff;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // The instruction leaving EX on this edge may itself set CF, so bypass it.
    assign flag_upd = vld_p1 & flag_we_p1;
    assign cf_eff   = flag_upd ? alu_flags[CF] : flags_q[CF];

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            alu_op_p1   <= '0;
            rs1_addr_p1 <= '0;
            rs2_addr_p1 <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            use_imm_p1  <= 1'b0;
            rd_addr_p1  <= '0;
            reg_we_p1   <= 1'b0;
            flag_we_p1  <= 1'b0;
        end else if (flush) begin
            vld_p1      <= 1'b0;
            alu_op_p1   <= '0;
            rs1_addr_p1 <= '0;
            rs2_addr_p1 <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            use_imm_p1  <= 1'b0;
            rd_addr_p1  <= '0;
            reg_we_p1   <= 1'b0;
            flag_we_p1  <= 1'b0;
        end else if (!stall) begin
            vld_p1      <= id_valid;
            alu_op_p1   <= carry_convert(id_alu_op, id_carry_use, cf_eff);
            rs1_addr_p1 <= id_rs1_addr;
            rs2_addr_p1 <= id_rs2_addr;
            rs1_data_p1 <= id_rs1_data;
            rs2_data_p1 <= id_rs2_data;
            imm_p1      <= id_imm;
            use_imm_p1  <= id_use_imm;
            rd_addr_p1  <= id_rd_addr;
            reg_we_p1   <= id_reg_we;
            flag_we_p1  <= id_flag_we;
        end
    end

    // A stalled or flushed EX instruction must not commit its flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags_q <= 3'b000;
        else if (flag_upd && !stall && !flush)
            flags_q <= alu_flags;
    end

    // ---- EX stage (combinational) ----
    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
        .rs_addr       (rs1_addr_p1),
        .rf_data       (rs1_data_p1),
        .exmem_reg_we  (exmem_reg_we),
        .exmem_rd_addr (exmem_rd_addr),
        .exmem_result  (exmem_result),
        .memwb_reg_we  (memwb_reg_we),
        .memwb_rd_addr (memwb_rd_addr),
        .memwb_result  (memwb_result),
        .operand       (fwd_a)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
        .rs_addr       (rs2_addr_p1),
        .rf_data       (rs2_data_p1),
        .exmem_reg_we  (exmem_reg_we),
        .exmem_rd_addr (exmem_rd_addr),
        .exmem_result  (exmem_result),
        .memwb_reg_we  (memwb_reg_we),
        .memwb_rd_addr (memwb_rd_addr),
        .memwb_result  (memwb_result),
        .operand       (fwd_b)
    );

    assign ex_valid    = vld_p1;
    assign ex_alu_op   = alu_op_p1;
    assign ex_operandA = fwd_a;
    assign ex_operandB = use_imm_p1 ? imm_p1 : fwd_b;
    assign ex_rd_addr  = rd_addr_p1;
    assign ex_reg_we   = vld_p1 & reg_we_p1;
    assign ex_flag_we  = vld_p1 & flag_we_p1;

endmodule
